// File: rtl/noc_eject_port.sv
// Receive-side endpoint for one crossbar output lane: DEPTH-entry flit FIFO with
// valid/ready eject, occupancy count and sticky overflow/misroute flags.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module noc_eject_port #(
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int DEPTH      = 4,
   parameter int DEST_BITS  = 2,
   parameter logic [DEST_BITS-1:0] PORT_ID = '0
) (
   input  logic                        clk,
   input  logic                        rst_l,
   input  logic                        FIFO_ENQ,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] FIFO_IN,
   output logic                        FIFO_FULL,
   output logic                        EJ_VALID,
   output logic [ADDR_WIDTH-1:0]       EJ_ADDR,
   output logic [DATA_WIDTH-1:0]       EJ_DATA,
   input  logic                        EJ_READY,
   output logic [$clog2(DEPTH+1)-1:0]  COUNT,
   output logic                        OVERFLOW,
   output logic                        MISROUTE,
   input  logic                        CLR_ERR
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } flit_t;

   flit_t            mem [DEPTH];
   flit_t            head;
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count;
   logic             full, valid, accept, deq, dest_bad;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // Status decodes come only from registered occupancy, so no input-to-full path.
   assign full     = (count == CW'(DEPTH));
   assign valid    = (count != '0);
   assign accept   = FIFO_ENQ & ~full;
   assign deq      = valid & EJ_READY;
   assign dest_bad = (FIFO_IN[DATA_WIDTH +: DEST_BITS] != PORT_ID);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         OVERFLOW <= 1'b0;
         MISROUTE <= 1'b0;
      end else begin
         if (accept) wr_ptr <= next_ptr(wr_ptr);
         if (deq)    rd_ptr <= next_ptr(rd_ptr);
         case ({accept, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A new error in the clearing cycle wins over the clear.
         OVERFLOW <= (FIFO_ENQ & full)      | (OVERFLOW & ~CLR_ERR);
         MISROUTE <= (accept & dest_bad)    | (MISROUTE & ~CLR_ERR);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= flit_t'(FIFO_IN);
   end

   // Head is forced to zero while empty so stale entries never leak out.
   assign head      = valid ? mem[rd_ptr] : '0;
   assign EJ_ADDR   = head.addr;
   assign EJ_DATA   = head.data;
   assign EJ_VALID  = valid;
   assign FIFO_FULL = full;
   assign COUNT     = count;

endmodule

// File: tb/tb_noc_eject_port.sv
// Scoreboard bench for noc_eject_port: queue model of accepted flits and flags,
// compared against the DUT on every falling clock edge.
module tb_noc_eject_port;
   localparam int AW = 4, DW = 8, D = 4, DB = 2, W = AW + DW;
   localparam logic [DB-1:0] PID = 2'd1;

   logic          clk = 1'b0;
   logic          rst_l;
   logic          FIFO_ENQ, EJ_READY, CLR_ERR;
   logic [W-1:0]  FIFO_IN;
   logic          FIFO_FULL, EJ_VALID, OVERFLOW, MISROUTE;
   logic [AW-1:0] EJ_ADDR;
   logic [DW-1:0] EJ_DATA;
   logic [2:0]    COUNT;

   always #5 clk = ~clk;

   noc_eject_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D), .DEST_BITS(DB), .PORT_ID(PID)) dut (
      .clk(clk), .rst_l(rst_l), .FIFO_ENQ(FIFO_ENQ), .FIFO_IN(FIFO_IN), .FIFO_FULL(FIFO_FULL),
      .EJ_VALID(EJ_VALID), .EJ_ADDR(EJ_ADDR), .EJ_DATA(EJ_DATA), .EJ_READY(EJ_READY),
      .COUNT(COUNT), .OVERFLOW(OVERFLOW), .MISROUTE(MISROUTE), .CLR_ERR(CLR_ERR)
   );

   int           n_run = 0, n_fail = 0;
   logic [W-1:0] sb[$];
   bit           movf = 1'b0, mmis = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state();
      logic [W-1:0] h;
      chk("count", 32'(COUNT), 32'(sb.size()));
      chk("valid", 32'(EJ_VALID), 32'(sb.size() != 0));
      chk("full",  32'(FIFO_FULL), 32'(sb.size() == D));
      chk("ovf",   32'(OVERFLOW), 32'(movf));
      chk("mis",   32'(MISROUTE), 32'(mmis));
      if (sb.size() != 0) begin
         h = sb[0];
         chk("addr", 32'(EJ_ADDR), 32'(h[W-1:DW]));
         chk("data", 32'(EJ_DATA), 32'(h[DW-1:0]));
      end
   endtask

   // One clock: drive, check pre-edge state at negedge, advance model, cross posedge.
   task automatic cyc(input bit enq, input logic [W-1:0] flit, input bit rdy, input bit clr);
      bit full, acc, dq;
      FIFO_ENQ = enq; FIFO_IN = flit; EJ_READY = rdy; CLR_ERR = clr;
      @(negedge clk);
      check_state();
      full = (sb.size() == D);
      acc  = enq && !full;
      dq   = rdy && (sb.size() != 0);
      movf = (enq && full) || (movf && !clr);
      mmis = (acc && (flit[DW +: DB] != PID)) || (mmis && !clr);
      if (dq)  void'(sb.pop_front());
      if (acc) sb.push_back(flit);
      @(posedge clk); #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_count"}, 32'(COUNT), 0);
      chk({tag, "_valid"}, 32'(EJ_VALID), 0);
      chk({tag, "_full"},  32'(FIFO_FULL), 0);
      chk({tag, "_ovf"},   32'(OVERFLOW), 0);
      chk({tag, "_mis"},   32'(MISROUTE), 0);
      chk({tag, "_addr"},  32'(EJ_ADDR), 0);
      chk({tag, "_data"},  32'(EJ_DATA), 0);
   endtask

   initial begin
      rst_l = 1'b0; FIFO_ENQ = 0; FIFO_IN = '0; EJ_READY = 0; CLR_ERR = 0;
      repeat (3) @(posedge clk);
      #1 chk_all_zero("in_rst");
      rst_l = 1'b1;
      repeat (3) cyc(0, '0, 0, 0);

      // Mid-stream reset with two flits buffered.
      cyc(1, 12'h1A1, 0, 0);
      cyc(1, 12'h1B2, 0, 0);
      cyc(0, '0, 0, 0);
      chk("pre_rst_count", 32'(COUNT), 2);
      rst_l = 1'b0;
      #1 chk_all_zero("async_rst");
      sb.delete(); movf = 0; mmis = 0;
      @(posedge clk); #1 chk_all_zero("rst_hold");
      rst_l = 1'b1;
      cyc(0, '0, 1, 0);

      // Fill to full with the endpoint stalled.
      cyc(1, 12'h1A1, 0, 0);
      chk("lat1_valid", 32'(EJ_VALID), 1);
      cyc(1, 12'h1B2, 0, 0);
      cyc(1, 12'h1C3, 0, 0);
      cyc(1, 12'h1D4, 0, 0);
      chk("full_at4", 32'(FIFO_FULL), 1);

      // Enqueue while full with a simultaneous dequeue: flit dropped.
      cyc(1, 12'h1EE, 1, 0);
      chk("ovf_set", 32'(OVERFLOW), 1);
      chk("ovf_count", 32'(COUNT), 3);
      chk("full_drop", 32'(FIFO_FULL), 0);
      repeat (4) cyc(0, '0, 1, 0);

      // Streaming: write pointer wraps repeatedly at constant occupancy.
      for (int i = 0; i < 10; i++) cyc(1, {4'h1, 8'(i)}, 1, 0);
      chk("stream_count", 32'(COUNT), 1);
      repeat (2) cyc(0, '0, 1, 0);

      // Misroute detection, clear, and set-wins-over-clear.
      cyc(1, 12'h2FF, 0, 0);
      chk("mis_set", 32'(MISROUTE), 1);
      chk("mis_addr", 32'(EJ_ADDR), 2);
      chk("mis_data", 32'(EJ_DATA), 8'hFF);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 0, 1);
      chk("clr_mis", 32'(MISROUTE), 0);
      chk("clr_ovf", 32'(OVERFLOW), 0);
      cyc(1, 12'h2FF, 0, 1);
      chk("mis_setwins", 32'(MISROUTE), 1);
      cyc(0, '0, 1, 1);
      cyc(0, '0, 0, 0);

      // Random enqueue/ready toggling against the scoreboard.
      for (int i = 0; i < 200; i++)
         cyc(1'($urandom_range(0, 1)),
             {2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0) ? PID : 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 255))},
             1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      repeat (6) cyc(0, '0, 1, 0);
      chk("drained", 32'(COUNT), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
